// File: rtl/hdb3_pkg.sv
// rtl/hdb3_pkg.sv - shared HDB3 symbol codes, window tags and helpers
// Purpose: constants shared by the HDB3 encoder and decoder so that both
//          ends of the line-code path agree on the 2-bit ternary format.
// Contents:
//   HDB3_ZERO / HDB3_POS / HDB3_NEG : ternary symbol codes (2'b11 unused)
//   tag_t                           : window slot tags ZERO / MARK / B / V
//   WIN_DEPTH                       : substitution window depth (4 bits)
//   pol_sym()                       : pulse polarity flag to symbol code
package hdb3_pkg;

  localparam logic [1:0] HDB3_ZERO = 2'b00;
  localparam logic [1:0] HDB3_POS  = 2'b01;
  localparam logic [1:0] HDB3_NEG  = 2'b10;

  typedef enum logic [1:0] {
    TAG_ZERO = 2'd0,
    TAG_MARK = 2'd1,
    TAG_B    = 2'd2,
    TAG_V    = 2'd3
  } tag_t;

  localparam int WIN_DEPTH = 4;
  localparam int FILL_W    = 3;

  // neg = 1 selects a -1 pulse, neg = 0 a +1 pulse.
  function automatic logic [1:0] pol_sym(input logic neg);
    return neg ? HDB3_NEG : HDB3_POS;
  endfunction

endpackage

// File: rtl/hdb3_enc.sv
// rtl/hdb3_enc.sv - HDB3 line encoder (NRZ bits in, ternary symbols out)
// Purpose: AMI marking with 000V / B00V substitution of every run of four
//          zeros. A 4-slot tag window delays each bit by four accepted bits
//          so a B pulse can be inserted ahead of a zero run once it is seen.
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   data_valid : qualifies data_in, one bit accepted per edge while high
//   data_in    : NRZ bit, 1 = mark
//   hdb3_valid : registered, high one cycle per emitted symbol
//   hdb3_out   : registered symbol, 00 zero / 01 +1 / 10 -1
module hdb3_enc
  import hdb3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       data_in,
  output logic       hdb3_valid,
  output logic [1:0] hdb3_out
);

  tag_t              win      [WIN_DEPTH];
  tag_t              win_next [WIN_DEPTH];
  logic [FILL_W-1:0] fill;
  logic              last_neg;       // polarity of the last pulse, 1 = -1
  logic              par;            // pulses since last V, 1 = odd

  logic              emit;
  logic [1:0]        sym;
  logic              last_neg_next;
  logic              par_next;
  logic              all_zero;

  always_comb begin
    emit          = data_valid && (fill == FILL_W'(WIN_DEPTH));
    sym           = HDB3_ZERO;
    last_neg_next = last_neg;
    par_next      = par;

    // Output stage: encode the oldest tag as it leaves the window.
    if (emit) begin
      case (win[WIN_DEPTH-1])
        TAG_MARK, TAG_B: begin
          last_neg_next = ~last_neg;
          par_next      = ~par;
          sym           = pol_sym(~last_neg);
        end
        TAG_V: begin
          // Violation repeats the previous polarity and restarts parity.
          sym      = pol_sym(last_neg);
          par_next = 1'b0;
        end
        default: sym = HDB3_ZERO;
      endcase
    end

    win_next[0] = data_in ? TAG_MARK : TAG_ZERO;
    for (int i = 1; i < WIN_DEPTH; i++) begin
      win_next[i] = win[i-1];
    end

    // Any non-ZERO tag (mark or part of an earlier group) blocks detection,
    // which keeps substitution groups from overlapping.
    all_zero = 1'b1;
    for (int i = 0; i < WIN_DEPTH; i++) begin
      if (win_next[i] != TAG_ZERO) all_zero = 1'b0;
    end

    // Only a window holding four real bits may be substituted; reset filler
    // slots must never be mistaken for a zero run.
    if (all_zero && (fill >= FILL_W'(WIN_DEPTH - 1))) begin
      win_next[0] = TAG_V;
      if (!par_next) win_next[WIN_DEPTH-1] = TAG_B;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) win[i] <= TAG_ZERO;
      fill       <= '0;
      last_neg   <= 1'b1;
      par        <= 1'b0;
      hdb3_valid <= 1'b0;
      hdb3_out   <= HDB3_ZERO;
    end else begin
      hdb3_valid <= emit;
      if (data_valid) begin
        win      <= win_next;
        last_neg <= last_neg_next;
        par      <= par_next;
        if (fill != FILL_W'(WIN_DEPTH)) fill <= fill + 1'b1;
        if (emit) hdb3_out <= sym;
      end
    end
  end

endmodule

// File: tb/tb_hdb3_enc.sv
// tb/tb_hdb3_enc.sv - scoreboard bench for hdb3_enc with reference model
module tb_hdb3_enc;

  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] Z = 2'b00;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_valid = 1'b0;
  logic       data_in = 1'b0;
  logic       hdb3_valid;
  logic [1:0] hdb3_out;

  int n_checks = 0;
  int n_fail   = 0;

  bit         stim[$];
  logic [1:0] exp_syms[$];
  logic [1:0] sb[$];
  logic [1:0] rec[$];
  int         acc = 0;
  bit         exp_v = 1'b0;
  bit         chk_en = 1'b0;
  int         zrun = 0;

  hdb3_enc dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data_in    (data_in),
    .hdb3_valid (hdb3_valid),
    .hdb3_out   (hdb3_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a symbol.
  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_valid", int'(hdb3_valid), 0);
      chk("reset_out", int'(hdb3_out), 0);
      zrun = 0;
    end else if (chk_en) begin
      chk("valid_timing", int'(hdb3_valid), int'(exp_v));
      if (hdb3_valid) begin
        logic [1:0] e;
        chk("no_sym_11", int'(hdb3_out == 2'b11), 0);
        if (sb.size() == 0) begin
          chk("sb_underflow", 0, 1);
        end else begin
          e = sb.pop_front();
          chk("symbol", int'(hdb3_out), int'(e));
        end
        zrun = (hdb3_out == Z) ? zrun + 1 : 0;
        chk("zero_run_lt4", int'(zrun >= 4), 0);
        rec.push_back(hdb3_out);
      end
    end
  end

  task automatic send(input bit v, input bit d);
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    exp_v = v && (acc >= 4);
    if (v) acc++;
    #1;
  endtask

  task automatic do_reset();
    data_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", int'(hdb3_valid), 0);
    chk("async_rst_out", int'(hdb3_out), 0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    rst = 1'b1;
    acc = 0;
    exp_v = 1'b0;
    sb.delete();
    rec.delete();
  endtask

  task automatic load_bits(input int n, input logic [31:0] v);
    stim.delete();
    for (int i = n - 1; i >= 0; i--) stim.push_back(v[i]);
  endtask

  // Reference: textbook HDB3 over the whole bit list. Bits are encoded
  // left to right; on the fourth zero of a run the group is rewritten as
  // 000V or B00V depending on pulses since the last violation.
  task automatic model_encode();
    int pol = -1;
    int pulses = 0;
    int zeros = 0;
    int s[$];
    foreach (stim[i]) begin
      if (stim[i]) begin
        pol = -pol;
        s.push_back(pol);
        pulses++;
        zeros = 0;
      end else begin
        s.push_back(0);
        zeros++;
        if (zeros == 4) begin
          if (pulses % 2 == 0) begin
            pol = -pol;
            s[s.size()-4] = pol;
          end
          s[s.size()-1] = pol;
          pulses = 0;
          zeros = 0;
        end
      end
    end
    exp_syms.delete();
    foreach (s[i]) exp_syms.push_back(s[i] > 0 ? P : (s[i] < 0 ? N : Z));
  endtask

  // gap_mode 0: continuous, 1: alternate idle cycles, 2: random idles.
  task automatic run_stream(input int gap_mode, input bit tail);
    chk_en = 1'b1;
    foreach (stim[j]) begin
      if (j >= 4) sb.push_back(exp_syms[j-4]);
      send(1'b1, stim[j]);
      if (gap_mode == 1) send(1'b0, 1'($urandom_range(0, 1)));
      if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) send(1'b0, 1'($urandom_range(0, 1)));
      end
    end
    if (tail) begin
      repeat (3) send(1'b0, 1'($urandom_range(0, 1)));
      chk("sb_drained", sb.size(), 0);
    end
  endtask

  task automatic loopback_check();
    int lastp = 0;
    int errs = 0;
    bit d[$];
    foreach (rec[i]) begin
      int p;
      p = (rec[i] == P) ? 1 : ((rec[i] == N) ? -1 : 0);
      if (p != 0 && p == lastp) begin
        d.push_back(1'b0);
        for (int k = 1; k <= 3; k++) if (i - k >= 0) d[i-k] = 1'b0;
      end else begin
        d.push_back(p != 0);
      end
      if (p != 0) lastp = p;
    end
    chk("loopback_len", d.size(), stim.size() - 4);
    for (int i = 0; i < d.size() && i < stim.size(); i++) begin
      if (d[i] != stim[i]) errs++;
    end
    chk("loopback_bits", errs, 0);
  endtask

  initial begin
    // Reset held with random input activity.
    rst = 1'b0;
    repeat (20) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rst = 1'b1;
    acc = 0;

    // All ones.
    load_bits(8, 32'hFF);
    exp_syms = {P, N, P, N};
    run_stream(0, 1'b1);

    // Mid-stream reset right after a symbol is presented.
    sb.push_back(P);
    send(1'b1, 1'b1);
    chk("pre_rst_valid", int'(hdb3_valid), 1);
    do_reset();

    // Odd parity: 000V.
    load_bits(10, 32'b1000011111);
    exp_syms = {P, Z, Z, Z, P, N};
    run_stream(0, 1'b1);
    do_reset();

    // Even parity: B00V twice, then padding.
    load_bits(16, 32'b0000000011111111);
    exp_syms = {P, Z, Z, P, N, Z, Z, N, P, N, P, N};
    run_stream(0, 1'b1);
    do_reset();

    // Odd-parity stream with alternating valid.
    load_bits(10, 32'b1000011111);
    exp_syms = {P, Z, Z, Z, P, N};
    run_stream(1, 1'b1);
    do_reset();

    // Short continuous random stream.
    stim.delete();
    repeat (200) stim.push_back($urandom_range(0, 2) == 0);
    model_encode();
    run_stream(0, 1'b1);
    loopback_check();
    do_reset();

    // Long random stream with random gaps, plus loopback decode.
    stim.delete();
    repeat (10000) stim.push_back($urandom_range(0, 2) == 0);
    model_encode();
    run_stream(2, 1'b1);
    loopback_check();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
